threshold_hyst: RTL and testbench

Parametrised successor to the single-threshold pulse detector in the RPM counter front end. It sits between the ADC sample interface and the RPM counter. Incoming samples are qualified by a toggle strobe and compared against runtime-programmable high and low thresholds with hysteresis. A crossing must persist for a configurable number of consecutive samples before it is accepted. Each confirmed rising crossing emits a one-cycle pulse, and the block reports the number of samples between consecutive pulses.

---
 rtl/threshold_hyst.sv | 91 +++++++++
 tb/tb_threshold_hyst.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_hyst.sv
// threshold_hyst: strobe-qualified ADC threshold detector with hysteresis, debounce,
// rising-crossing pulse and saturating sample-period measurement.
module threshold_hyst #(
    parameter int ADC_WIDTH = 12,
    parameter int DEBOUNCE  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADC_WIDTH-1:0] adc_value,
    input  logic                 adc_value_change,
    input  logic [ADC_WIDTH-1:0] thr_high,
    input  logic [ADC_WIDTH-1:0] thr_low,
    output logic                 pulse,
    output logic                 level,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid
);
    typedef enum logic [1:0] {LOW, ARM_HIGH, HIGH, ARM_LOW} state_t;
    localparam logic [3:0] DB = 4'(DEBOUNCE);
    state_t state, state_n;
    logic [3:0] dcnt, dcnt_n, dcnt_inc;
    logic chg_q, smp, ge_high, le_low, rise, seen;
    logic [CNT_WIDTH-1:0] scnt, scnt_inc;
    assign smp      = adc_value_change != chg_q;
    assign ge_high  = adc_value >= thr_high;
    assign le_low   = adc_value <= thr_low;
    assign dcnt_inc = dcnt + 4'd1;
    assign scnt_inc = &scnt ? scnt : scnt + 1'b1;
    // only a move from the low side into HIGH is a rising crossing
    assign rise     = !level && state_n == HIGH;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOW;
            dcnt  <= 4'd0;
        end else begin
            state <= state_n;
            dcnt  <= dcnt_n;
        end
    end
    always_comb begin
        state_n = state;
        dcnt_n  = dcnt;
        if (smp) begin
            case (state)
                LOW: if (ge_high) begin
                    state_n = DB == 4'd1 ? HIGH : ARM_HIGH;
                    dcnt_n  = DB == 4'd1 ? 4'd0 : 4'd1;
                end
                ARM_HIGH: begin
                    state_n = !ge_high ? LOW : (dcnt_inc == DB ? HIGH : ARM_HIGH);
                    dcnt_n  = (ge_high && dcnt_inc != DB) ? dcnt_inc : 4'd0;
                end
                HIGH: if (le_low) begin
                    state_n = DB == 4'd1 ? LOW : ARM_LOW;
                    dcnt_n  = DB == 4'd1 ? 4'd0 : 4'd1;
                end
                ARM_LOW: begin
                    state_n = !le_low ? HIGH : (dcnt_inc == DB ? LOW : ARM_LOW);
                    dcnt_n  = (le_low && dcnt_inc != DB) ? dcnt_inc : 4'd0;
                end
            endcase
        end
    end
    always_comb begin
        level = state == HIGH || state == ARM_LOW;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chg_q        <= 1'b0;
            pulse        <= 1'b0;
            scnt         <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            seen         <= 1'b0;
        end else begin
            chg_q <= adc_value_change;
            pulse <= rise;
            if (rise) begin
                scnt <= '0;
                seen <= 1'b1;
                if (seen) begin
                    period       <= scnt_inc;
                    period_valid <= 1'b1;
                end
            end else if (smp) begin
                scnt <= scnt_inc;
            end
        end
    end
endmodule

// File: tb/tb_threshold_hyst.sv
// tb_threshold_hyst: two threshold_hyst instances (default and DEBOUNCE=3/CNT_WIDTH=4)
// checked every cycle against a streak-counting model, plus directed literal checks.
module tb_threshold_hyst;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] adc_value = 12'd0;
    logic        adc_value_change = 1'b0;
    logic [11:0] thr_high = 12'd3000;
    logic [11:0] thr_low = 12'd1000;
    logic        pulse_a, level_a, valid_a, pulse_b, level_b, valid_b;
    logic [15:0] period_a;
    logic [3:0]  period_b;
    int n_chk = 0;
    int n_fail = 0;

    threshold_hyst dut_a (
        .clk(clk), .rst_n(rst_n), .adc_value(adc_value), .adc_value_change(adc_value_change),
        .thr_high(thr_high), .thr_low(thr_low), .pulse(pulse_a), .level(level_a),
        .period(period_a), .period_valid(valid_a)
    );
    threshold_hyst #(.DEBOUNCE(3), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .adc_value(adc_value), .adc_value_change(adc_value_change),
        .thr_high(thr_high), .thr_low(thr_low), .pulse(pulse_b), .level(level_b),
        .period(period_b), .period_valid(valid_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: level flips after D consecutive qualifying samples; counters are plain ints
    int  md[2] = '{2, 3};
    int  mmax[2] = '{65535, 15};
    bit  m_level[2], m_pulse[2], m_valid[2], m_seen[2];
    int  m_streak[2], m_cnt[2], m_period[2];
    bit  m_prev, m_q;
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_pulse[k] = 1'b0;
            if (!rst_n) begin
                m_level[k] = 1'b0; m_valid[k] = 1'b0; m_seen[k] = 1'b0;
                m_streak[k] = 0; m_cnt[k] = 0; m_period[k] = 0;
            end else if (adc_value_change != m_prev) begin
                m_q = m_level[k] ? adc_value <= thr_low : adc_value >= thr_high;
                m_streak[k] = m_q ? m_streak[k] + 1 : 0;
                m_cnt[k] = m_cnt[k] < mmax[k] ? m_cnt[k] + 1 : mmax[k];
                if (m_streak[k] == md[k]) begin
                    m_streak[k] = 0;
                    m_level[k] = !m_level[k];
                    if (m_level[k]) begin
                        m_pulse[k] = 1'b1;
                        if (m_seen[k]) begin
                            m_period[k] = m_cnt[k];
                            m_valid[k] = 1'b1;
                        end
                        m_seen[k] = 1'b1;
                        m_cnt[k] = 0;
                    end
                end
            end
        end
        m_prev = rst_n ? adc_value_change : 1'b0;
        #1;
        chk("pulse_a", pulse_a, m_pulse[0]);
        chk("level_a", level_a, m_level[0]);
        chk("period_a", period_a, m_period[0]);
        chk("valid_a", valid_a, m_valid[0]);
        chk("pulse_b", pulse_b, m_pulse[1]);
        chk("level_b", level_b, m_level[1]);
        chk("period_b", period_b, m_period[1]);
        chk("valid_b", valid_b, m_valid[1]);
    end

    task automatic send(input int v);
        @(negedge clk);
        adc_value = 12'(v);
        adc_value_change = ~adc_value_change;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        adc_value = 12'd0;
        adc_value_change = 1'b0;
        thr_high = 12'd3000;
        thr_low = 12'd1000;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int pick_adc();
        int r;
        r = $urandom_range(7);
        return r == 0 ? 0 : r == 1 ? int'(thr_low) : r == 2 ? int'(thr_low) + 1 :
               r == 3 ? int'(thr_high) : r == 4 ? int'(thr_high) - 1 : r == 5 ? 4095 :
               int'($urandom_range(4095));
    endfunction

    int seq8[8] = '{0, 0, 4095, 4095, 0, 0, 4095, 4095};
    int seq6[6] = '{4095, 4095, 2000, 4095, 4095, 4095};

    initial begin
        idle(2);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_level", level_a, 0);
        chk("rst_pulse", pulse_a, 0);
        chk("rst_period", period_a, 0);
        chk("rst_valid", valid_a, 0);
        // slow strobe, paired samples
        send(4095);
        chk("slow_lvl1", level_a, 0);
        idle(63);
        send(4095);
        chk("slow_pulse1", pulse_a, 1);
        chk("slow_lvl2", level_a, 1);
        chk("slow_valid1", valid_a, 0);
        chk("slow_period1", period_a, 0);
        @(posedge clk);
        #1;
        chk("slow_pulse_w", pulse_a, 0);
        idle(62);
        send(0);
        idle(63);
        send(0);
        chk("slow_lvl3", level_a, 0);
        idle(63);
        send(4095);
        idle(63);
        send(4095);
        chk("slow_pulse2", pulse_a, 1);
        chk("slow_valid2", valid_a, 1);
        chk("slow_period2", period_a, 4);
        // debounce reject on the DEBOUNCE=3 instance
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(seq6[i]);
            chk("db_level", level_b, i == 5 ? 1 : 0);
            chk("db_pulse", pulse_b, i == 5 ? 1 : 0);
        end
        // hysteresis band and inclusive low compare
        do_reset();
        send(4095);
        send(4095);
        for (int i = 0; i < 10; i++) begin
            send(2000);
            chk("hy_level", level_a, 1);
            chk("hy_pulse", pulse_a, 0);
        end
        send(1000);
        chk("hy_arm", level_a, 1);
        send(1000);
        chk("hy_low", level_a, 0);
        // back-to-back strobes
        do_reset();
        for (int i = 0; i < 8; i++) begin
            send(seq8[i]);
            chk("bb_pulse", pulse_a, (i == 3 || i == 7) ? 1 : 0);
        end
        chk("bb_period", period_a, 4);
        chk("bb_valid", valid_a, 1);
        // async reset while armed, with a sample pending on the next edge
        send(0);
        send(0);
        send(4095);
        chk("ar_armed", level_a, 0);
        @(negedge clk);
        adc_value = 12'd4095;
        adc_value_change = ~adc_value_change;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_level", level_a, 0);
        chk("ar_pulse", pulse_a, 0);
        chk("ar_period", period_a, 0);
        chk("ar_valid", valid_a, 0);
        @(posedge clk);
        #1;
        chk("ar_nopulse", pulse_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_post", pulse_a, 0);
        // saturation on the 4-bit counter instance
        do_reset();
        repeat (3) send(4095);
        repeat (17) send(0);
        repeat (3) send(4095);
        chk("sat_pulse_b", pulse_b, 1);
        chk("sat_period_b", period_b, 15);
        chk("sat_valid_b", valid_b, 1);
        chk("sat_period_a", period_a, 20);
        // random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (c % 256 == 0) begin
                thr_high = $urandom_range(3) == 0 ? 12'($urandom_range(4095)) : 12'd3000;
                thr_low = $urandom_range(3) == 0 ? 12'($urandom_range(4095)) : 12'd1000;
            end
            rst_n = $urandom_range(499) != 0;
            adc_value = 12'(pick_adc());
            if ($urandom_range(1) == 1) adc_value_change = ~adc_value_change;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
